accum_sched: RTL

- Sequencing controller placed in front of, and behind, the float accumulator stream block (float_accu wrapper) in the YOLO post-processing path.
- Takes a frame of FP32 words from DMA and cuts it into cfg_groups accumulation groups of cfg_elems words each, by injecting TLAST into the accumulator input stream.
- Forwards the per-group sums to the output stream, with TLAST on the final sum of the frame.
- Reports busy/done/error status to the host control logic.

---
 rtl/accum_sched.sv | 92 +++++++++
 1 files changed

// File: rtl/accum_sched.sv
// accum_sched: cuts a DMA frame into accumulation groups for the float accumulator
// and forwards the per-group sums to the DMA write stream.
module accum_sched #(
    parameter int CNT_W = 32
) (
    input  logic             AXIS_ACLK,
    input  logic             AXIS_ARESET,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_elems,
    input  logic [CNT_W-1:0] cfg_groups,
    output logic             busy,
    output logic             done,
    output logic             err_early_last,
    input  logic             S_AXIS_TVALID,
    output logic             S_AXIS_TREADY,
    input  logic [31:0]      S_AXIS_TDATA,
    input  logic [1:0]       S_AXIS_TKEEP,
    input  logic             S_AXIS_TLAST,
    output logic             A_AXIS_TVALID,
    input  logic             A_AXIS_TREADY,
    output logic [31:0]      A_AXIS_TDATA,
    output logic             A_AXIS_TLAST,
    input  logic             R_AXIS_TVALID,
    output logic             R_AXIS_TREADY,
    input  logic [31:0]      R_AXIS_TDATA,
    input  logic             R_AXIS_TLAST,
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic [31:0]      M_AXIS_TDATA,
    output logic [1:0]       M_AXIS_TKEEP,
    output logic             M_AXIS_TLAST
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;
    logic [CNT_W-1:0] elems, groups, elem_cnt, grp_in_cnt, grp_out_cnt;
    logic data_word, s_hs, a_hs, m_hs, last_in, unused_r_last;
    assign unused_r_last = R_AXIS_TLAST;
    assign data_word = S_AXIS_TKEEP == 2'b11;
    assign busy = state != IDLE;
    assign A_AXIS_TVALID = state == RUN && S_AXIS_TVALID && data_word;
    assign A_AXIS_TDATA = S_AXIS_TDATA;
    assign A_AXIS_TLAST = elem_cnt == elems - CNT_W'(1);
    // null words are swallowed here and never reach the accumulator
    assign S_AXIS_TREADY = state == RUN && (A_AXIS_TREADY || !data_word);
    assign s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
    assign a_hs = A_AXIS_TVALID && A_AXIS_TREADY;
    assign last_in = A_AXIS_TLAST && grp_in_cnt == groups - CNT_W'(1);
    assign M_AXIS_TVALID = R_AXIS_TVALID && busy;
    assign R_AXIS_TREADY = M_AXIS_TREADY || !busy;
    assign M_AXIS_TDATA = R_AXIS_TDATA;
    assign M_AXIS_TKEEP = 2'b11;
    assign M_AXIS_TLAST = grp_out_cnt == groups - CNT_W'(1);
    assign m_hs = M_AXIS_TVALID && M_AXIS_TREADY;
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state <= IDLE;
            elems <= '0;
            groups <= '0;
            elem_cnt <= '0;
            grp_in_cnt <= '0;
            grp_out_cnt <= '0;
            done <= 1'b0;
            err_early_last <= 1'b0;
        end else begin
            done <= 1'b0;
            if (a_hs) elem_cnt <= A_AXIS_TLAST ? '0 : elem_cnt + CNT_W'(1);
            if (a_hs && A_AXIS_TLAST) grp_in_cnt <= grp_in_cnt + CNT_W'(1);
            if (m_hs) grp_out_cnt <= grp_out_cnt + CNT_W'(1);
            if (s_hs && S_AXIS_TLAST && !(a_hs && last_in)) err_early_last <= 1'b1;
            case (state)
                IDLE: if (cfg_start && cfg_elems != '0 && cfg_groups != '0) begin
                    elems <= cfg_elems;
                    groups <= cfg_groups;
                    elem_cnt <= '0;
                    grp_in_cnt <= '0;
                    grp_out_cnt <= '0;
                    err_early_last <= 1'b0;
                    state <= RUN;
                end
                RUN: if (a_hs && last_in) state <= DRAIN;
                DRAIN: if (m_hs && M_AXIS_TLAST) begin
                    state <= IDLE;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // the accumulator has at least one cycle of latency, so the final sum cannot meet the final input
    assert property (@(posedge AXIS_ACLK) disable iff (AXIS_ARESET)
        !(state == RUN && a_hs && last_in && m_hs && M_AXIS_TLAST));
endmodule
